// File: rtl/byte_arb_pkg.sv
// -----------------------------------------------------------------------------
// byte_arb_pkg
// Shared types and helpers for the byte_arbiter round-robin memory arbiter.
//   - ARB_* localparams   : default configuration of the arbiter
//   - idx_width()         : width of a user index for a given user count
//   - user_idx_t          : user index type sized by the default user count
//   - access_t            : one access record (isWrite, mask, addr, data)
//   - rr_wrap()           : modulo-USER wrap of an index that may exceed USER-1
// -----------------------------------------------------------------------------
package byte_arb_pkg;

  localparam int ARB_USER      = 3;
  localparam int ARB_DATA_BYTE = 4;
  localparam int ARB_ADDR_SIZE = 32;

  // A single requester still needs a 1-bit index to keep vectors legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int USER_IDX_W = idx_width(ARB_USER);

  typedef logic [USER_IDX_W-1:0] user_idx_t;

  typedef struct packed {
    logic                         is_write;
    logic [ARB_DATA_BYTE-1:0]     mask;
    logic [ARB_ADDR_SIZE-1:0]     addr;
    logic [ARB_DATA_BYTE*8-1:0]   data;
  } access_t;

  // Inputs are always below 2*n, so one conditional subtract is enough.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/byte_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// byte_rr_pick
// Combinational rotate/find-first: returns the first set request found when
// searching start, start+1, ... wrapping modulo N.
// Ports:
//   req   in  [N]     request vector
//   start in  [IDX_W] index the search begins at
//   found out 1       at least one request set
//   idx   out [IDX_W] index of the selected request (0 when none)
// -----------------------------------------------------------------------------
module byte_rr_pick
  import byte_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Requests rotated so that bit k corresponds to user (start + k) mod N.
  logic [N-1:0] rot;

  always_comb begin
    rot = N'({req, req} >> start);
  end

  // Walk from the far end so the lowest rotated position wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = IDX_W'(rr_wrap(int'(start) + k, N));
      end
    end
  end

endmodule

// File: rtl/byte_arbiter.sv
// -----------------------------------------------------------------------------
// byte_arbiter
// Round-robin arbiter sharing one byte-addressed memory port among USER
// requesters on the Enable/Hold/WriteMask bus. A stalled access stays locked
// to its owner, one user gets at most MAX_BURST back-to-back accepts while
// others wait, and one-cycle-latency read data is tagged to the issuer.
//
// Optional feature: define BYTE_ARB_STARVE_EN to add per-user wait counters
// and the registered starve_o flag (port absent otherwise).
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   useEnable_i    [U]     request per user
//   useIsWrite_i   [U]     write when 1
//   useWriteMask_i [U][DB] byte enables
//   useAddr_i      [U][A]  address
//   useWriteData_i [U][D]  write data
//   useReadData_o  [U][D]  memReadData_i broadcast to every user
//   useReadValid_o [U]     read data valid for this user
//   useHold_o      [U]     stall to each user
//   mem*_o                 downstream request (muxed from the granted user)
//   memReadData_i          downstream read data (1 cycle after accept)
//   memHold_i              downstream stall
//   starve_o               some user has waited STARVE_LIMIT cycles
// -----------------------------------------------------------------------------
module byte_arbiter
  import byte_arb_pkg::*;
#(
  parameter int USER         = ARB_USER,
  parameter int DATA_BYTE    = ARB_DATA_BYTE,
  parameter int ADDR_SIZE    = ARB_ADDR_SIZE,
  parameter int MAX_BURST    = 2,
  parameter int HOLDENABLE   = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [USER-1:0]                     useEnable_i,
  input  logic [USER-1:0]                     useIsWrite_i,
  input  logic [USER-1:0][DATA_BYTE-1:0]      useWriteMask_i,
  input  logic [USER-1:0][ADDR_SIZE-1:0]      useAddr_i,
  input  logic [USER-1:0][DATA_BYTE*8-1:0]    useWriteData_i,
  output logic [USER-1:0][DATA_BYTE*8-1:0]    useReadData_o,
  output logic [USER-1:0]                     useReadValid_o,
  output logic [USER-1:0]                     useHold_o,
  output logic                                memEnable_o,
  output logic                                memIsWrite_o,
  output logic [DATA_BYTE-1:0]                memWriteMask_o,
  output logic [ADDR_SIZE-1:0]                memAddr_o,
  output logic [DATA_BYTE*8-1:0]              memWriteData_o,
  input  logic [DATA_BYTE*8-1:0]              memReadData_i,
  input  logic                                memHold_i
`ifdef BYTE_ARB_STARVE_EN
  ,
  output logic                                starve_o
`endif
);

  localparam int IDX_W = idx_width(USER);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  if (USER < 2 || MAX_BURST < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("byte_arbiter: USER must be >= 2, MAX_BURST and STARVE_LIMIT >= 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] ptr_reg,       ptr_next;
  logic [IDX_W-1:0] owner_reg,     owner_next;
  logic             locked_reg,    locked_next;
  logic [BC_W-1:0]  burst_cnt_reg, burst_cnt_next;
  logic             rd_pend_reg,   rd_pend_next;
  logic [IDX_W-1:0] rd_user_reg,   rd_user_next;

  logic             found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] grant;
  logic             req_valid;
  logic             accept;
  logic [BC_W-1:0]  cnt;

  byte_rr_pick #(
    .N     (USER),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (useEnable_i),
    .start (ptr_reg),
    .found (found),
    .idx   (pick_idx)
  );

  // A locked owner is never re-arbitrated; its request is taken at face value
  // because a held user must keep Enable and fields stable. Reset masks the
  // request combinationally so memEnable_o drops the moment rst_ni falls.
  always_comb begin
    grant     = locked_reg ? owner_reg : pick_idx;
    req_valid = rst_ni && (locked_reg ? useEnable_i[owner_reg] : found);
    accept    = req_valid && !memHold_i;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg       <= '0;
      owner_reg     <= '0;
      locked_reg    <= 1'b0;
      burst_cnt_reg <= '0;
      rd_pend_reg   <= 1'b0;
      rd_user_reg   <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      locked_reg    <= locked_next;
      burst_cnt_reg <= burst_cnt_next;
      rd_pend_reg   <= rd_pend_next;
      rd_user_reg   <= rd_user_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_next       = ptr_reg;
    burst_cnt_next = burst_cnt_reg;

    // The burst run continues only while the winner is the user at ptr;
    // any other winner starts a fresh run of length 1.
    cnt = (grant == ptr_reg) ? burst_cnt_reg + BC_W'(1) : BC_W'(1);

    if (accept) begin
      if (cnt == BC_W'(MAX_BURST)) begin
        ptr_next       = IDX_W'(rr_wrap(int'(grant) + 1, USER));
        burst_cnt_next = '0;
      end else begin
        ptr_next       = grant;
        burst_cnt_next = cnt;
      end
    end

    locked_next  = req_valid && memHold_i;
    owner_next   = grant;

    rd_pend_next = accept && !useIsWrite_i[grant];
    rd_user_next = rd_pend_next ? grant : rd_user_reg;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    memEnable_o    = req_valid;
    memIsWrite_o   = 1'b0;
    memWriteMask_o = '0;
    memAddr_o      = '0;
    memWriteData_o = '0;
    if (req_valid) begin
      memIsWrite_o   = useIsWrite_i[grant];
      memWriteMask_o = useWriteMask_i[grant];
      memAddr_o      = useAddr_i[grant];
      memWriteData_o = useWriteData_i[grant];
    end
  end

  for (genvar gi = 0; gi < USER; gi++) begin : g_user
    logic granted;
    logic idle_hold;

    assign granted   = req_valid && (grant == IDX_W'(gi));
    assign idle_hold = (HOLDENABLE != 0) ? useEnable_i[gi] : 1'b1;

    assign useHold_o[gi]      = !rst_ni ? 1'b1 : (granted ? memHold_i : idle_hold);
    assign useReadValid_o[gi] = rd_pend_reg && (rd_user_reg == IDX_W'(gi));
    assign useReadData_o[gi]  = memReadData_i;
  end

`ifdef BYTE_ARB_STARVE_EN
  // ---------------------------------------------------------------------------
  // Starvation monitor
  // ---------------------------------------------------------------------------
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [USER-1:0] starve_hit;
  logic            starve_reg, starve_next;

  for (genvar gi = 0; gi < USER; gi++) begin : g_starve
    logic [SC_W-1:0] wait_reg, wait_next;

    always_comb begin
      wait_next = wait_reg;
      if (!useEnable_i[gi] || (accept && grant == IDX_W'(gi))) begin
        wait_next = '0;
      end else if (wait_reg != SC_W'(STARVE_LIMIT)) begin
        wait_next = wait_reg + SC_W'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wait_reg <= '0;
      end else begin
        wait_reg <= wait_next;
      end
    end

    assign starve_hit[gi] = (wait_reg == SC_W'(STARVE_LIMIT));
  end

  always_comb begin
    starve_next = |starve_hit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_reg <= 1'b0;
    end else begin
      starve_reg <= starve_next;
    end
  end

  assign starve_o = starve_reg;
`endif

endmodule

// File: doc/byte_arbiter.md
# byte_arbiter

Registered-state round-robin arbiter sharing one byte-addressed memory port among `USER` requesters on the Enable/Hold/WriteMask bus used throughout the memory/byte tree. It sits in front of a single SRAM or ByteMux downstream port. It keeps a stalled transaction stable, limits how many back-to-back accesses one user gets (`MAX_BURST`), and tags one-cycle-latency read data back to the issuing user.

## Interface
- `USER`, 3: number of requesters, ≥2
- `DATA_BYTE`, 4: bus width in bytes
- `ADDR_SIZE`, 32: address width
- `MAX_BURST`, 2: consecutive accepted accesses one user may take while others wait, ≥1; 1 gives pure round-robin
- `HOLDENABLE`, 1: 1 means a non-granted user sees Hold only when its Enable is set; 0 means Hold is asserted regardless
- `STARVE_LIMIT`, 64: wait-cycle threshold, used only with `BYTE_ARB_STARVE_EN`
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous reset, active low
- `useEnable_i` in [USER]×1: request
- `useIsWrite_i` in [USER]×1: write when 1
- `useWriteMask_i` in [USER]×DATA_BYTE: byte enables
- `useAddr_i` in [USER]×ADDR_SIZE: address
- `useWriteData_i` in [USER]×DATA_BYTE*8: write data
- `useReadData_o` out [USER]×DATA_BYTE*8: `memReadData_i` broadcast to all users
- `useReadValid_o` out [USER]×1: read data valid for this user
- `useHold_o` out [USER]×1: stall
- `memEnable_o`, `memIsWrite_o`, `memWriteMask_o`, `memAddr_o`, `memWriteData_o` out: downstream request
- `memReadData_i` in DATA_BYTE*8: downstream read data
- `memHold_i` in 1: downstream stall
- `starve_o` out 1: starvation flag; present only with `BYTE_ARB_STARVE_EN`

## Operation
- State registers, all reset to 0: `ptr` (start index), `owner`, `locked`, `burstCnt` (width $clog2(MAX_BURST+1)), `rdPend`, `rdUser`.
- Grant selection:
  - If `locked`: grant = `owner`.
  - Otherwise: grant = first user with Enable set, searching `ptr`, `ptr+1`, … and wrapping modulo `USER`.
- `memEnable_o` = any eligible request. The other mem outputs mux the granted user's fields. With no request they are 0.
- Hold outputs:
  - Granted user: `useHold_o` = `memHold_i`.
  - Other users: `useHold_o` = 1, gated by their Enable when `HOLDENABLE`=1.
- Accept = `memEnable_o && !memHold_i`. On accept:
  - `cnt` = (grant==`ptr`) ? `burstCnt`+1 : 1.
  - If `cnt`==`MAX_BURST`: `ptr`←grant+1 (wrap), `burstCnt`←0.
  - Else: `ptr`←grant, `burstCnt`←`cnt`.
- Stall: `locked`←`memEnable_o && memHold_i` and `owner`←grant every cycle. Protocol rule: a user must keep Enable and fields stable while held. The arbiter never re-arbitrates a stalled access.
- Read return: on an accepted read, `rdPend`←1 and `rdUser`←grant; otherwise `rdPend`←0. `useReadValid_o[u]` = `rdPend && rdUser==u`.
- Write accepts never raise ReadValid.

## Timing
- Request to memory: combinational, 0 cycles.
- Read data: valid exactly 1 cycle after the accept cycle.
- Back-to-back reads by different users are allowed; each ReadValid lands on the cycle after its own accept.
- Grant changes only in cycles following an accept or a cycle with no locked state.
- While `rst_ni` is low, outputs are:
  - `memEnable_o`=0
  - all `useHold_o`=1
  - all `useReadValid_o`=0
  - `starve_o`=0
- Reset mid-stall drops the transaction. The requester must reissue it after reset.
- A lone requester is never throttled: when `ptr` rotates past it, the wrapped search still selects it in the same cycle.
- A simultaneous new request at a higher-priority index does not preempt a locked owner.

## Configuration
- `BYTE_ARB_STARVE_EN` defined:
  - Per-user wait counters, saturating at `STARVE_LIMIT`.
  - A counter increments while the user's Enable is set and it is not accepted, and clears on accept or when Enable drops.
  - `starve_o` = OR of (counter==`STARVE_LIMIT`), registered.
- Undefined: counters and `starve_o` are absent.

## Structure
- Package `byte_arb_pkg`:
  - `user_idx_t` sized by `USER` via a parameterized localparam pattern.
  - The access-record struct (isWrite, mask, addr, data).
  - Function `rr_wrap(idx, USER)`.
- Sub-module `byte_rr_pick`: combinational rotate/find-first. Inputs: request vector and start index. Outputs: found bit and index.

## Test plan
- USER=3, MAX_BURST=2; users 0,1,2 hold Enable continuously with no stall → accept order 0,0,1,1,2,2,0.
- MAX_BURST=1, same stimulus → order 0,1,2,0,1,2.
- User 1 alone reads addr 0x10; `memReadData_i`=0xA5A5A5A5 the next cycle → `useReadValid_o`=3'b010 in that cycle only, with data 0xA5A5A5A5.
- User 2 is granted and `memHold_i`=1 for 3 cycles while user 0 raises Enable → `memAddr_o` stays at user 2's address, `useHold_o[0]`=1, and user 2 is accepted on cycle 4.
- HOLDENABLE=0, user 0 is granted and user 1 idle → `useHold_o[1]`=1. With HOLDENABLE=1 → `useHold_o[1]`=0.
- `BYTE_ARB_STARVE_EN` with STARVE_LIMIT=4; `memHold_i` stuck at 1 while user 0 is locked and user 1 is waiting → `starve_o`=1 after 5 cycles. Asserting `rst_ni` low mid-stall → `starve_o`=0 and `memEnable_o`=0 immediately.
